mac_pwr_ctrl: RTL and testbench
===============================

MAC_PWR_CTRL -- requirements
Module: mac_pwr_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2: cycles the MAC datapath is stalled before isolation (range 1..15).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: cycles allowed for rails to settle after switch-on (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  mode-change request valid.
REQ-006 SHALL have port req_mode  input  3  requested mode code.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port mode_ack  output  1  one-cycle pulse when a transition completes or a same-mode request is accepted.
REQ-009 SHALL have port mode_err  output  1  one-cycle pulse when an illegal code is rejected.
REQ-010 SHALL have port state_select  output  3  mode code driven to the MAC state_select input.
REQ-011 SHALL have ports sw_ml, sw_mh, sw_al, sw_ah  output  1 each  enables for rails VddML, VddMH, VddAL, VddAH.
REQ-012 SHALL have port al_boost  output  1  selects the high (1.2 V) level on VddAL.
REQ-013 SHALL have port iso_en  output  1  isolation clamp on MAC outputs, active high.
REQ-014 SHALL have port mac_en  output  1  input-stream enable to the MAC; stimulus is held while low.

Function
REQ-015 Legal codes SHALL be OFF=000, RPM=001, LPM=011, ESM=010, FPM=110; all other codes SHALL be illegal.
REQ-016 Rail map SHALL be: OFF none; RPM ml+al; LPM ml+ah; ESM mh+al; FPM mh+al with al_boost=1; al_boost SHALL be 0 in every other mode.
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE.
REQ-018 An illegal req_mode SHALL produce mode_err the following cycle with no change to any other output.
REQ-019 A legal req_mode equal to the current mode SHALL produce mode_ack the following cycle with no sequence.
REQ-020 Any other legal request SHALL run the FSM IDLE -> DRAIN -> ISO -> BREAK -> MAKE -> SETTLE -> RELEASE -> IDLE.
REQ-021 DRAIN SHALL last DRAIN_CYCLES cycles with mac_en=0; the other outputs hold.
REQ-022 ISO SHALL last 1 cycle and assert iso_en.
REQ-023 BREAK SHALL last 1 cycle and clear the enables of rails not used by the target mode; rails shared by both modes stay on (break-before-make).
REQ-024 MAKE SHALL last 1 cycle, set the target rail enables and al_boost, and update state_select to the target code.
REQ-025 SETTLE SHALL last SETTLE_CYCLES cycles, counted by a down-counter loaded on entry.
REQ-026 RELEASE SHALL last 1 cycle, deassert iso_en and assert mac_en; if the target is OFF, iso_en SHALL stay 1 and mac_en SHALL stay 0.
REQ-027 mode_ack SHALL pulse in the first IDLE cycle after RELEASE, exactly DRAIN_CYCLES+SETTLE_CYCLES+4 edges after the accept edge (10 with default parameters).
REQ-028 req_valid SHALL be ignored while req_ready=0, with no queuing and no error.
REQ-029 mode_ack and mode_err SHALL never be asserted in the same cycle.

Reset
REQ-030 On reset assertion, with no clock required: state_select=000, all sw_*=0, al_boost=0, iso_en=1, mac_en=0, req_ready=1, mode_ack=0, mode_err=0, FSM=IDLE, current mode=OFF.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence and force the REQ-030 values immediately.
REQ-032 Reset deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-033 Reset, then request RPM -> sw_ml=sw_al=1 in MAKE; state_select=001; iso_en=0, mac_en=1 and mode_ack at accept+10.
REQ-034 From RPM, request LPM -> sw_al=0 in BREAK while sw_ml stays 1; sw_ah=1 in MAKE; state_select=011; mac_en=0 for the whole transition.
REQ-035 From ESM, request FPM -> sw_mh and sw_al stay 1 throughout; al_boost=1 from MAKE; state_select=110; mode_ack at +10.
REQ-036 In IDLE, req_mode=101 -> mode_err pulse next cycle, all other outputs unchanged; same-mode request -> mode_ack next cycle.
REQ-037 Second request during SETTLE -> ignored; req_ready=0 until IDLE; only one mode_ack.
REQ-038 Reset asserted during SETTLE -> all outputs take REQ-030 values asynchronously; a fresh RPM request then completes normally.

Source files
------------

// File: rtl/mac_pwr_ctrl.sv
// ---------------------------------------------------------------------------
// mac_pwr_ctrl
//
// Power-mode controller for a multi-rail MAC. It accepts a mode-change request
// and steps the rails through a safe sequence:
//   stall the datapath -> clamp outputs -> break unused rails -> make target
//   rails -> wait for rails to settle -> release clamp and restart datapath.
//
// Mode codes: OFF=000, RPM=001, LPM=011, ESM=010, FPM=110 (others illegal).
// Rail map:   OFF none | RPM ml+al | LPM ml+ah | ESM mh+al | FPM mh+al+boost
//
// Parameters
//   DRAIN_CYCLES  : cycles the datapath is stalled before isolation (1..15)
//   SETTLE_CYCLES : cycles allowed for rails to settle after switch-on (1..255)
//
// Ports
//   clk          : single clock
//   reset        : asynchronous active-high reset
//   req_valid    : mode-change request valid
//   req_mode     : requested mode code
//   req_ready    : high only while idle; a request is taken on valid & ready
//   mode_ack     : one-cycle pulse on completion or same-mode accept
//   mode_err     : one-cycle pulse when an illegal code is rejected
//   state_select : mode code driven to the MAC
//   sw_ml/mh/al/ah : rail enables for VddML, VddMH, VddAL, VddAH
//   al_boost     : selects the high level on VddAL
//   iso_en       : output isolation clamp, active high
//   mac_en       : MAC input-stream enable
// ---------------------------------------------------------------------------
module mac_pwr_ctrl #(
    parameter int unsigned DRAIN_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_mode,
    output logic       req_ready,
    output logic       mode_ack,
    output logic       mode_err,
    output logic [2:0] state_select,
    output logic       sw_ml,
    output logic       sw_mh,
    output logic       sw_al,
    output logic       sw_ah,
    output logic       al_boost,
    output logic       iso_en,
    output logic       mac_en
);

    localparam logic [2:0] MODE_OFF = 3'b000;
    localparam logic [2:0] MODE_RPM = 3'b001;
    localparam logic [2:0] MODE_LPM = 3'b011;
    localparam logic [2:0] MODE_ESM = 3'b010;
    localparam logic [2:0] MODE_FPM = 3'b110;

    // Counters load N-1 and leave the state when they reach zero, so a state
    // entered with this load value lasts exactly N cycles.
    localparam logic [7:0] DRAIN_LOAD  = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ISO,
        ST_BREAK,
        ST_MAKE,
        ST_SETTLE,
        ST_RELEASE
    } state_t;

    // Rail vector order: {ml, mh, al, ah}
    function automatic logic [3:0] rails_of(input logic [2:0] mode);
        logic [3:0] r;
        case (mode)
            MODE_RPM: r = 4'b1010;
            MODE_LPM: r = 4'b1001;
            MODE_ESM: r = 4'b0110;
            MODE_FPM: r = 4'b0110;
            default:  r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic is_legal(input logic [2:0] mode);
        return (mode == MODE_OFF) || (mode == MODE_RPM) || (mode == MODE_LPM) ||
               (mode == MODE_ESM) || (mode == MODE_FPM);
    endfunction

    state_t     state_q,    state_d;
    logic [7:0] cnt_q,      cnt_d;
    logic [2:0] cur_mode_q, cur_mode_d;
    logic [2:0] tgt_mode_q, tgt_mode_d;
    logic [2:0] sel_q,      sel_d;
    logic [3:0] rails_q,    rails_d;
    logic       boost_q,    boost_d;
    logic       iso_q,      iso_d;
    logic       mac_q,      mac_d;
    logic       ready_q,    ready_d;
    logic       ack_q,      ack_d;
    logic       err_q,      err_d;

    logic       accept;
    logic [3:0] tgt_rails;

    // ready_q is only high in IDLE; the state term keeps accept safe even if
    // the two ever disagreed.
    assign accept    = req_valid && ready_q && (state_q == ST_IDLE);
    assign tgt_rails = rails_of(tgt_mode_q);

    // Every output is a register written on entry to the state that owns it,
    // so output changes line up with state changes and nothing glitches.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_mode_d = cur_mode_q;
        tgt_mode_d = tgt_mode_q;
        sel_d      = sel_q;
        rails_d    = rails_q;
        boost_d    = boost_q;
        iso_d      = iso_q;
        mac_d      = mac_q;
        ready_d    = ready_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_legal(req_mode)) begin
                        err_d = 1'b1;
                    end else if (req_mode == cur_mode_q) begin
                        ack_d = 1'b1;
                    end else begin
                        tgt_mode_d = req_mode;
                        cnt_d      = DRAIN_LOAD;
                        mac_d      = 1'b0;
                        ready_d    = 1'b0;
                        state_d    = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (cnt_q == 8'd0) begin
                    iso_d   = 1'b1;
                    state_d = ST_ISO;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_ISO: begin
                // Break before make: only rails shared with the target survive.
                rails_d = rails_q & tgt_rails;
                state_d = ST_BREAK;
            end

            ST_BREAK: begin
                rails_d = tgt_rails;
                boost_d = (tgt_mode_q == MODE_FPM);
                sel_d   = tgt_mode_q;
                state_d = ST_MAKE;
            end

            ST_MAKE: begin
                cnt_d   = SETTLE_LOAD;
                state_d = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    // With all rails off the MAC stays clamped and stalled.
                    if (tgt_mode_q != MODE_OFF) begin
                        iso_d = 1'b0;
                        mac_d = 1'b1;
                    end
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_RELEASE: begin
                ack_d      = 1'b1;
                ready_d    = 1'b1;
                cur_mode_d = tgt_mode_q;
                state_d    = ST_IDLE;
            end

            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            cur_mode_q <= MODE_OFF;
            tgt_mode_q <= MODE_OFF;
            sel_q      <= MODE_OFF;
            rails_q    <= 4'b0000;
            boost_q    <= 1'b0;
            iso_q      <= 1'b1;
            mac_q      <= 1'b0;
            ready_q    <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_mode_q <= cur_mode_d;
            tgt_mode_q <= tgt_mode_d;
            sel_q      <= sel_d;
            rails_q    <= rails_d;
            boost_q    <= boost_d;
            iso_q      <= iso_d;
            mac_q      <= mac_d;
            ready_q    <= ready_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign req_ready    = ready_q;
    assign mode_ack     = ack_q;
    assign mode_err     = err_q;
    assign state_select = sel_q;
    assign sw_ml        = rails_q[3];
    assign sw_mh        = rails_q[2];
    assign sw_al        = rails_q[1];
    assign sw_ah        = rails_q[0];
    assign al_boost     = boost_q;
    assign iso_en       = iso_q;
    assign mac_en       = mac_q;

endmodule

// File: tb/tb_mac_pwr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_pwr_ctrl
//
// Directed bench for mac_pwr_ctrl with default parameters (DRAIN=2, SETTLE=4).
// Outputs are packed into one 13-bit vector
//   {req_ready, mode_ack, mode_err, state_select[2:0], ml, mh, al, ah,
//    al_boost, iso_en, mac_en}
// and compared against hand-derived expectations one cycle at a time.
// ---------------------------------------------------------------------------
module tb_mac_pwr_ctrl;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_mode;
    logic       req_ready;
    logic       mode_ack;
    logic       mode_err;
    logic [2:0] state_select;
    logic       sw_ml, sw_mh, sw_al, sw_ah;
    logic       al_boost;
    logic       iso_en;
    logic       mac_en;

    int checks = 0;
    int errors = 0;

    // Bench-side record of the settled outputs between transitions.
    logic [2:0] cur_ss;
    logic [3:0] cur_rails;
    logic       cur_boost;
    logic       cur_iso;
    logic       cur_mac;

    mac_pwr_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_mode     (req_mode),
        .req_ready    (req_ready),
        .mode_ack     (mode_ack),
        .mode_err     (mode_err),
        .state_select (state_select),
        .sw_ml        (sw_ml),
        .sw_mh        (sw_mh),
        .sw_al        (sw_al),
        .sw_ah        (sw_ah),
        .al_boost     (al_boost),
        .iso_en       (iso_en),
        .mac_en       (mac_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] out_vec();
        return {req_ready, mode_ack, mode_err, state_select,
                sw_ml, sw_mh, sw_al, sw_ah, al_boost, iso_en, mac_en};
    endfunction

    function automatic logic [12:0] mk_vec(input logic rdy, input logic ack, input logic err,
                                           input logic [2:0] ss, input logic [3:0] rails,
                                           input logic boost, input logic iso, input logic mac);
        return {rdy, ack, err, ss, rails, boost, iso, mac};
    endfunction

    // Rail table {ml, mh, al, ah}
    function automatic logic [3:0] rails_tbl(input logic [2:0] m);
        case (m)
            3'b001:  return 4'b1010;
            3'b011:  return 4'b1001;
            3'b010:  return 4'b0110;
            3'b110:  return 4'b0110;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic set_reset_state();
        cur_ss    = 3'b000;
        cur_rails = 4'b0000;
        cur_boost = 1'b0;
        cur_iso   = 1'b1;
        cur_mac   = 1'b0;
    endtask

    task automatic check_reset_vec(input string tag);
        check_eq(tag, 32'(out_vec()), 32'(mk_vec(1'b1, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b0)));
    endtask

    // Full mode change. Sample k is taken 1 time unit after edge accept+k.
    // inject: pulse a second request during SETTLE (must be ignored).
    // abort:  assert reset asynchronously during SETTLE and stop.
    task automatic do_trans(input logic [2:0] tgt, input bit inject, input bit abort);
        logic [3:0]  tr;
        logic        tb_boost;
        logic        live;
        logic [12:0] exp;
        logic [3:0]  er;
        tr       = rails_tbl(tgt);
        tb_boost = (tgt == 3'b110);
        live     = (tgt != 3'b000);
        @(negedge clk);
        req_valid = 1'b1;
        req_mode  = tgt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (k < 3)       er = cur_rails;
            else if (k == 3) er = cur_rails & tr;
            else             er = tr;
            exp = mk_vec(k >= 10, k == 10, 1'b0,
                         (k >= 4) ? tgt : cur_ss,
                         er,
                         (k >= 4) ? tb_boost : cur_boost,
                         (k < 2) ? cur_iso : ((k >= 9 && live) ? 1'b0 : 1'b1),
                         (k >= 9 && live) ? 1'b1 : 1'b0);
            check_eq($sformatf("trans_%03b_k%0d", tgt, k), 32'(out_vec()), 32'(exp));
            if (abort && k == 6) begin
                #2;
                reset = 1'b1;
                #1;
                check_reset_vec("async_reset_in_settle");
                set_reset_state();
                @(negedge clk);
                reset = 1'b0;
                $display("transaction: request %03b aborted by reset during SETTLE", tgt);
                return;
            end
            if (inject && k == 5) begin
                @(negedge clk);
                req_valid = 1'b1;
                req_mode  = 3'b010;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
        cur_ss    = tgt;
        cur_rails = tr;
        cur_boost = tb_boost;
        cur_iso   = !live;
        cur_mac   = live;
        $display("transaction: mode change to %03b%s complete", tgt,
                 inject ? " (with ignored request in SETTLE)" : "");
    endtask

    // Request that must not start a sequence: illegal code or current mode.
    task automatic do_single(input logic [2:0] m, input bit is_err);
        logic [12:0] hold;
        hold = mk_vec(1'b1, 1'b0, 1'b0, cur_ss, cur_rails, cur_boost, cur_iso, cur_mac);
        @(negedge clk);
        req_valid = 1'b1;
        req_mode  = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq($sformatf("single_%03b_pulse", m), 32'(out_vec()),
                 32'(hold | {1'b0, !is_err, is_err, 10'b0}));
        @(posedge clk);
        #1;
        check_eq($sformatf("single_%03b_after", m), 32'(out_vec()), 32'(hold));
        $display("transaction: %s request %03b", is_err ? "illegal" : "same-mode", m);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_mode  = 3'b000;
        set_reset_state();
        #3;
        check_reset_vec("reset_initial");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vec("after_reset_release");

        do_trans(3'b001, 1'b0, 1'b0);   // OFF -> RPM
        do_trans(3'b011, 1'b0, 1'b0);   // RPM -> LPM, al breaks, ml shared
        do_trans(3'b010, 1'b0, 1'b0);   // LPM -> ESM
        do_trans(3'b110, 1'b0, 1'b0);   // ESM -> FPM, mh/al stay, boost
        do_single(3'b101, 1'b1);        // illegal code
        do_single(3'b110, 1'b0);        // same mode
        do_single(3'b111, 1'b1);        // illegal code
        do_trans(3'b000, 1'b0, 1'b0);   // FPM -> OFF, stays isolated
        do_trans(3'b001, 1'b1, 1'b0);   // OFF -> RPM, second request ignored
        do_trans(3'b010, 1'b0, 1'b1);   // RPM -> ESM aborted by reset
        @(posedge clk);
        #1;
        check_reset_vec("idle_after_abort");
        do_trans(3'b001, 1'b0, 1'b0);   // fresh RPM after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
